// File: rtl/mdu_hilo.sv
`default_nettype none
// ============================================================================
//  Module   : mdu_hilo
//  Purpose  : HI/LO register unit. Captures multiply products, handles
//             MTHI/MTLO and runs a multi-cycle restoring DIV/DIVU.
//  Revision : 1.0  initial release
// ============================================================================
module mdu_hilo #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               op_valid,
  input  logic [2:0]         op,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  input  logic [2*WIDTH-1:0] product,
  output logic [WIDTH-1:0]   hi,
  output logic [WIDTH-1:0]   lo,
  output logic               busy,
  output logic               done
);

  localparam logic [2:0]       c_OP_MUL_WB = 3'b001;
  localparam logic [2:0]       c_OP_MTHI   = 3'b010;
  localparam logic [2:0]       c_OP_MTLO   = 3'b011;
  localparam logic [2:0]       c_OP_DIV    = 3'b100;
  localparam logic [2:0]       c_OP_DIVU   = 3'b101;
  localparam logic [CNT_W-1:0] c_CNT_INIT  = CNT_W'(WIDTH);
  localparam logic [CNT_W-1:0] c_CNT_ONE   = CNT_W'(1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_DIV  = 2'd1,
    S_FIX  = 2'd2
  } state_t;

  state_t             r_state;
  state_t             w_next;
  logic [CNT_W-1:0]   r_cnt;
  logic [WIDTH-1:0]   r_rem;
  logic [WIDTH-1:0]   r_quo;
  logic [WIDTH-1:0]   r_div;
  logic               r_neg_q;
  logic               r_neg_r;
  logic               r_dbz;
  logic [WIDTH-1:0]   r_hi;
  logic [WIDTH-1:0]   r_lo;
  logic               r_done;

  logic               w_accept;
  logic               w_is_div;
  logic               w_b_zero;
  logic               w_a_neg;
  logic               w_b_neg;
  logic [WIDTH-1:0]   w_a_mag;
  logic [WIDTH-1:0]   w_b_mag;
  logic [WIDTH:0]     w_rem_sh;
  logic [WIDTH-1:0]   w_trial;
  logic               w_ge;

  assign w_accept = op_valid && (r_state == S_IDLE);
  assign w_is_div = (op == c_OP_DIV) || (op == c_OP_DIVU);
  assign w_b_zero = (b == '0);
  assign w_a_neg  = (op == c_OP_DIV) && a[WIDTH-1];
  assign w_b_neg  = (op == c_OP_DIV) && b[WIDTH-1];
  assign w_a_mag  = w_a_neg ? (~a + 1'b1) : a;
  assign w_b_mag  = w_b_neg ? (~b + 1'b1) : b;

  // Shifted remainder is WIDTH+1 bits wide, so the compare never wraps; when it
  // succeeds the difference is below the divisor and fits in WIDTH bits.
  assign w_rem_sh = {r_rem, r_quo[WIDTH-1]};
  assign w_ge     = (w_rem_sh >= {1'b0, r_div});
  assign w_trial  = w_rem_sh[WIDTH-1:0] - r_div;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_accept && w_is_div) begin
          w_next = w_b_zero ? S_FIX : S_DIV;
        end
      end
      S_DIV: begin
        if (r_cnt == c_CNT_ONE) begin
          w_next = S_FIX;
        end
      end
      S_FIX:   w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cnt   <= '0;
      r_rem   <= '0;
      r_quo   <= '0;
      r_div   <= '0;
      r_neg_q <= 1'b0;
      r_neg_r <= 1'b0;
      r_dbz   <= 1'b0;
      r_hi    <= '0;
      r_lo    <= '0;
      r_done  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            case (op)
              c_OP_MUL_WB: begin
                r_hi <= product[2*WIDTH-1:WIDTH];
                r_lo <= product[WIDTH-1:0];
              end
              c_OP_MTHI: r_hi <= a;
              c_OP_MTLO: r_lo <= a;
              c_OP_DIV, c_OP_DIVU: begin
                // On divide-by-zero the raw dividend rides in r_quo to reach HI.
                r_quo   <= w_b_zero ? a : w_a_mag;
                r_div   <= w_b_mag;
                r_rem   <= '0;
                r_cnt   <= c_CNT_INIT;
                r_neg_q <= w_a_neg ^ w_b_neg;
                r_neg_r <= w_a_neg;
                r_dbz   <= w_b_zero;
              end
              default: ;
            endcase
          end
        end
        S_DIV: begin
          r_rem <= w_ge ? w_trial : w_rem_sh[WIDTH-1:0];
          r_quo <= {r_quo[WIDTH-2:0], w_ge};
          r_cnt <= r_cnt - c_CNT_ONE;
        end
        S_FIX: begin
          r_done <= 1'b1;
          if (r_dbz) begin
            r_hi <= r_quo;
            r_lo <= '1;
          end else begin
            r_lo <= r_neg_q ? (~r_quo + 1'b1) : r_quo;
            r_hi <= r_neg_r ? (~r_rem + 1'b1) : r_rem;
          end
        end
        default: ;
      endcase
    end
  end

  assign hi   = r_hi;
  assign lo   = r_lo;
  assign busy = (r_state != S_IDLE);
  assign done = r_done;

endmodule
`default_nettype wire

// File: tb/tb_mdu_hilo.sv
`default_nettype none
// ============================================================================
//  Module   : tb_mdu_hilo
//  Purpose  : Directed and randomized self-checking bench for mdu_hilo.
//  Revision : 1.0  initial release
// ============================================================================
module tb_mdu_hilo;
  localparam int W = 32;

  logic           clk = 1'b0;
  logic           reset;
  logic           op_valid;
  logic [2:0]     op;
  logic [W-1:0]   a;
  logic [W-1:0]   b;
  logic [2*W-1:0] product;
  logic [W-1:0]   hi;
  logic [W-1:0]   lo;
  logic           busy;
  logic           done;

  int n_vec = 0;
  int n_err = 0;
  logic [W-1:0] m_hi = '0;
  logic [W-1:0] m_lo = '0;

  mdu_hilo #(.WIDTH(W), .CNT_W(6)) dut (
    .clk(clk), .reset(reset), .op_valid(op_valid), .op(op), .a(a), .b(b),
    .product(product), .hi(hi), .lo(lo), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Reference: 64-bit signed/unsigned arithmetic, truncating division.
  function automatic void model_div(input logic [2:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
    longint sx, sy, q, r;
    if (y == '0) begin
      m_hi = x;
      m_lo = '1;
    end else if (o == 3'b100) begin
      sx = longint'($signed(x));
      sy = longint'($signed(y));
      q = sx / sy;
      r = sx % sy;
      m_lo = W'(q);
      m_hi = W'(r);
    end else begin
      m_lo = x / y;
      m_hi = x % y;
    end
  endfunction

  task automatic run_simple(input logic [2:0] o, input logic [W-1:0] x, input logic [2*W-1:0] p);
    @(negedge clk);
    op_valid = 1'b1; op = o; a = x; b = $urandom; product = p;
    @(negedge clk);
    op_valid = 1'b0;
    case (o)
      3'b001:  {m_hi, m_lo} = p;
      3'b010:  m_hi = x;
      3'b011:  m_lo = x;
      default: ;
    endcase
    check("simple_hi", hi, m_hi);
    check("simple_lo", lo, m_lo);
    check("simple_busy", busy, 1'b0);
    check("simple_done", done, 1'b0);
  endtask

  task automatic run_div(input logic [2:0] o, input logic [W-1:0] x, input logic [W-1:0] y, input int mtlo_at);
    int   cnt;
    logic stable;
    cnt = 0;
    stable = 1'b1;
    @(negedge clk);
    op_valid = 1'b1; op = o; a = x; b = y; product = {$urandom, $urandom};
    @(negedge clk);
    op_valid = 1'b0;
    while (busy === 1'b1 && cnt < 100) begin
      cnt++;
      if (hi !== m_hi || lo !== m_lo) stable = 1'b0;
      if (cnt == mtlo_at) begin
        op_valid = 1'b1; op = 3'b011; a = 32'd9;
      end
      @(negedge clk);
      op_valid = 1'b0;
    end
    model_div(o, x, y);
    check("div_busy_cycles", 64'(cnt), (y == '0) ? 64'd1 : 64'(W + 1));
    check("div_hilo_stable", stable, 1'b1);
    check("div_done", done, 1'b1);
    check("div_hi", hi, m_hi);
    check("div_lo", lo, m_lo);
    @(negedge clk);
    check("div_done_pulse_end", done, 1'b0);
  endtask

  initial begin
    logic        seen_done;
    logic [2:0]  ro;
    logic [W-1:0] rx, ry;

    reset = 1'b1; op_valid = 1'b0; op = '0; a = '0; b = '0; product = '0;
    repeat (2) @(negedge clk);
    check("rst_hi", hi, '0);
    check("rst_lo", lo, '0);
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    reset = 1'b0;

    run_simple(3'b001, '0, 64'h0000_0000_0000_0014);
    run_simple(3'b001, '0, 64'h0F93_D1E4_8E2B_3B29);
    run_simple(3'b010, 32'd7, '0);
    run_simple(3'b011, 32'd123, '0);
    run_simple(3'b110, 32'hDEAD_BEEF, 64'h1111_2222_3333_4444);
    run_simple(3'b000, 32'hCAFE_0000, 64'h5555_6666_7777_8888);

    run_div(3'b101, 32'd20, 32'd3, 0);
    run_div(3'b100, -32'sd7, 32'd2, 0);
    run_div(3'b100, 32'd5, 32'd0, 0);
    run_div(3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 0);
    run_div(3'b101, 32'hFFFF_FFFF, 32'd1, 0);
    run_div(3'b101, 32'd1000, 32'd7, 10);

    // Reset in the middle of a signed divide.
    run_simple(3'b001, '0, 64'hA5A5_A5A5_5A5A_5A5A);
    @(negedge clk);
    op_valid = 1'b1; op = 3'b100; a = -32'sd100; b = 32'd7;
    @(negedge clk);
    op_valid = 1'b0;
    repeat (14) @(negedge clk);
    check("mid_div_busy", busy, 1'b1);
    reset = 1'b1;
    #1;
    m_hi = '0; m_lo = '0;
    check("async_rst_hi", hi, m_hi);
    check("async_rst_lo", lo, m_lo);
    check("async_rst_busy", busy, 1'b0);
    @(negedge clk);
    reset = 1'b0;
    seen_done = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (done !== 1'b0) seen_done = 1'b1;
    end
    check("no_done_after_rst", seen_done, 1'b0);
    run_div(3'b101, 32'd100, 32'd10, 0);

    for (int i = 0; i < 200; i++) begin
      ro = 3'($urandom_range(0, 7));
      rx = $urandom;
      ry = ($urandom_range(0, 9) == 0) ? '0 : 32'($urandom >> $urandom_range(0, 31));
      if (ro == 3'b100 || ro == 3'b101)
        run_div(ro, rx, ry, ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 30)) : 0);
      else
        run_simple(ro, rx, {$urandom, $urandom});
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
`default_nettype wire
